// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between an instruction
// fetch requester (I) and a data requester (D). D has priority, but after
// STARVE_MAX consecutive D grants with a fetch waiting, I is forced through.
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [2:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [2:0] SIZE_WORD  = 3'b010;

  state_t     state;
  state_t     next_state;
  logic [2:0] starve_cnt;
  logic       i_live;
  logic       d_live;
  logic       grant_i;
  logic       grant_d;

  // A requester still showing its ready pulse has just been served, so it is
  // kept out of arbitration for that cycle; D wins ties unless I is starved.
  always_comb begin
    i_live     = i_req & ~i_ready;
    d_live     = d_req & ~d_ready;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        if (i_live && (!d_live || starve_cnt == STARVE_LIM)) begin
          grant_i    = 1'b1;
          next_state = IGNT;
        end else if (d_live) begin
          grant_d    = 1'b1;
          next_state = DGNT;
        end
      end
      IGNT:    if (m_ack) next_state = IDLE;
      DGNT:    if (m_ack) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Capture the winning request into the memory-side registers at grant time
  // so the memory sees fields that cannot change mid-transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_we    <= 1'b0;
      m_size  <= 3'b000;
      m_addr  <= 32'h0;
      m_wdata <= 32'h0;
    end else if (grant_i) begin
      m_we    <= 1'b0;
      m_size  <= SIZE_WORD;
      m_addr  <= i_addr;
    end else if (grant_d) begin
      m_we    <= d_we;
      m_size  <= d_size;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
    end
  end

  // Count D grants that overtook a waiting fetch; any other grant resets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (grant_i) begin
      starve_cnt <= 3'd0;
    end else if (grant_d) begin
      if (!i_live)                      starve_cnt <= 3'd0;
      else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 3'd1;
    end
  end

  // Completion: route memory read data to the granted port and pulse its ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      i_rdata <= 32'h0;
      d_rdata <= 32'h0;
    end else begin
      i_ready <= (state == IGNT) && m_ack;
      d_ready <= (state == DGNT) && m_ack;
      if ((state == IGNT) && m_ack) i_rdata <= m_rdata;
      if ((state == DGNT) && m_ack) d_rdata <= m_rdata;
    end
  end

  assign m_req = (state != IDLE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'h0;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_size = 3'b000;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [2:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata = 32'h0;
  logic        busy;

  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  assign m_ack = auto_ack ? m_req : man_ack;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if ({m_req, busy, i_ready, d_ready, m_we} !== 5'b0) begin failures++; $display("[TB] FAIL reset_ctrl: got %b expected 00000", {m_req, busy, i_ready, d_ready, m_we}); end
    checks++; if ({m_size, m_addr, m_wdata, i_rdata, d_rdata} !== 131'h0) begin failures++; $display("[TB] FAIL reset_data: got size=%h addr=%h wdata=%h irdata=%h drdata=%h expected all 0", m_size, m_addr, m_wdata, i_rdata, d_rdata); end
    reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_fetch_only();
    auto_ack = 1'b1;
    m_rdata  = 32'h00500093;
    i_addr   = 32'h100;
    i_req    = 1'b1;
    tick();
    checks++; if ({m_req, busy, m_we, m_size} !== 6'b110010) begin failures++; $display("[TB] FAIL fetch_grant: got req/busy/we/size=%b expected 110010", {m_req, busy, m_we, m_size}); end
    checks++; if (m_addr !== 32'h100) begin failures++; $display("[TB] FAIL fetch_addr: got %h expected 00000100", m_addr); end
    checks++; if (i_ready !== 1'b0) begin failures++; $display("[TB] FAIL fetch_early_ready: i_ready=%b expected 0", i_ready); end
    tick();
    i_req = 1'b0;
    checks++; if ({i_ready, d_ready, m_req} !== 3'b100) begin failures++; $display("[TB] FAIL fetch_ready: got i/d_ready,m_req=%b expected 100", {i_ready, d_ready, m_req}); end
    checks++; if (i_rdata !== 32'h00500093) begin failures++; $display("[TB] FAIL fetch_rdata: got %h expected 00500093", i_rdata); end
    tick();
    checks++; if (i_ready !== 1'b0) begin failures++; $display("[TB] FAIL fetch_pulse_len: i_ready=%b expected 0", i_ready); end
  endtask

  task automatic test_simultaneous();
    auto_ack = 1'b1;
    m_rdata  = 32'hAAAA0000;
    i_addr   = 32'h200;
    i_req    = 1'b1;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h2000;
    d_wdata  = 32'hDEADBEEF;
    d_size   = 3'b010;
    tick();
    checks++; if ({m_req, m_we, m_size} !== 5'b11010) begin failures++; $display("[TB] FAIL sim_d_first_ctrl: got req/we/size=%b expected 11010", {m_req, m_we, m_size}); end
    checks++; if ({m_addr, m_wdata} !== {32'h2000, 32'hDEADBEEF}) begin failures++; $display("[TB] FAIL sim_d_first_data: got addr=%h wdata=%h expected 00002000 deadbeef", m_addr, m_wdata); end
    tick();
    d_req   = 1'b0;
    d_we    = 1'b0;
    m_rdata = 32'h12345678;
    checks++; if ({d_ready, i_ready} !== 2'b10) begin failures++; $display("[TB] FAIL sim_d_ready: got d/i=%b expected 10", {d_ready, i_ready}); end
    tick();
    checks++; if ({m_req, m_we, m_size, m_addr} !== {1'b1, 1'b0, 3'b010, 32'h200}) begin failures++; $display("[TB] FAIL sim_i_next: got req=%b we=%b size=%b addr=%h expected 1 0 010 00000200", m_req, m_we, m_size, m_addr); end
    tick();
    i_req = 1'b0;
    checks++; if ({i_ready, d_ready} !== 2'b10) begin failures++; $display("[TB] FAIL sim_i_ready: got i/d=%b expected 10", {i_ready, d_ready}); end
    checks++; if ({i_rdata, d_rdata} !== {32'h12345678, 32'hAAAA0000}) begin failures++; $display("[TB] FAIL sim_rdata: got i=%h d=%h expected 12345678 aaaa0000", i_rdata, d_rdata); end
    tick();
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    m_rdata  = 32'hCAFEF00D;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_size   = 3'b001;
    d_addr   = 32'h3000;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (d_ready) pulses++;
      checks++; if ({m_req, m_addr} !== {1'b1, 32'h3000}) begin failures++; $display("[TB] FAIL wait_hold_%0d: got req=%b addr=%h expected 1 00003000", k, m_req, m_addr); end
      if (k == 4) man_ack = 1'b1;
    end
    tick();
    man_ack = 1'b0;
    d_req   = 1'b0;
    if (d_ready) pulses++;
    checks++; if ({d_ready, m_req, d_rdata} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin failures++; $display("[TB] FAIL wait_done: got ready=%b req=%b rdata=%h expected 1 0 cafef00d", d_ready, m_req, d_rdata); end
    checks++; if (i_rdata !== 32'h12345678) begin failures++; $display("[TB] FAIL wait_i_hold: got %h expected 12345678", i_rdata); end
    tick();
    if (d_ready) pulses++;
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL wait_pulses: got %0d expected 1", pulses); end
  endtask

  task automatic test_spurious_ack();
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if ({busy, m_req, i_ready, d_ready} !== 4'b0) begin failures++; $display("[TB] FAIL spurious_%0d: got busy/req/i/d=%b expected 0000", k, {busy, m_req, i_ready, d_ready}); end
    end
    man_ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b1;
    d_addr   = 32'h4000;
    d_wdata  = 32'h55AA55AA;
    d_size   = 3'b010;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_mid_busy: busy=%b expected 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({m_req, busy, i_ready, d_ready, m_we, m_size} !== 8'b0) begin failures++; $display("[TB] FAIL rst_async_ctrl: got %b expected 00000000", {m_req, busy, i_ready, d_ready, m_we, m_size}); end
    checks++; if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin failures++; $display("[TB] FAIL rst_async_data: got addr=%h wdata=%h i=%h d=%h expected all 0", m_addr, m_wdata, i_rdata, d_rdata); end
    #1;
    reset   = 1'b0;
    d_req   = 1'b0;
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    checks++; if ({d_ready, busy} !== 2'b00) begin failures++; $display("[TB] FAIL rst_late_ack: got ready/busy=%b expected 00", {d_ready, busy}); end
    tick();
    checks++; if (d_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_no_ready: d_ready=%b expected 0", d_ready); end
  endtask

  // Fetch waits behind D; the fetch requester withdraws during each D ready
  // bubble so D can win consecutive grants. Expect D,D,D,D then I, then D.
  task automatic test_starvation();
    logic exp_i;
    auto_ack = 1'b1;
    i_addr   = 32'h6000;
    d_addr   = 32'h5000;
    d_we     = 1'b0;
    for (int g = 0; g < 6; g++) begin
      exp_i   = (g == 4);
      m_rdata = 32'h1000 + g;
      i_req   = 1'b1;
      d_req   = 1'b1;
      tick();
      checks++; if ({m_req, m_addr} !== {1'b1, exp_i ? 32'h6000 : 32'h5000}) begin failures++; $display("[TB] FAIL starve_grant_%0d: got req=%b addr=%h expected 1 %h", g, m_req, m_addr, exp_i ? 32'h6000 : 32'h5000); end
      tick();
      checks++; if ({i_ready, d_ready} !== {exp_i, ~exp_i}) begin failures++; $display("[TB] FAIL starve_ready_%0d: got i/d=%b expected %b", g, {i_ready, d_ready}, {exp_i, ~exp_i}); end
      i_req = 1'b0;
      d_req = 1'b0;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_wait_states();
    test_spurious_ack();
    test_reset_mid_grant();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
